// File: rtl/led_shifter.sv
// LED pattern driver: steps a one-hot rotate/ping-pong pattern (or toggles all LEDs) once per rising edge
// of i_valid, with push-button mode select. Define LED_FLASH_EN to build in the FLASH mode on i_btn[3].
module led_shifter #(
    parameter int NB_LEDS = 4,
    parameter int NB_BTN  = 4
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic [1:0]         o_mode
);

    typedef enum logic [1:0] {
        SHIFT_L   = 2'b00,
        SHIFT_R   = 2'b01,
        PING_PONG = 2'b10,
        FLASH     = 2'b11
    } mode_t;

`ifdef LED_FLASH_EN
    localparam int NB_MODES = 4;
`else
    localparam int NB_MODES = 3;
`endif
    localparam int NB_SEL = (NB_BTN < NB_MODES) ? NB_BTN : NB_MODES;

    localparam logic [NB_LEDS-1:0] LED_LSB = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] LED_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    logic [NB_BTN-1:0]  btn_s1, btn_s2, btn_d, btn_rise;
    logic               valid_d, step;
    mode_t              mode_q, mode_n, sel_mode;
    logic               sel_hit;
    logic [NB_LEDS-1:0] led_q, led_n;
    logic               dir_q, dir_n;
    logic               led_onehot;
    logic               unused_rise;

    // i_valid is a level-type strobe with no ready: a step is taken only on its 0->1 transition,
    // so a level held high for many cycles produces exactly one step.
    assign step       = i_valid & ~valid_d;
    assign btn_rise   = btn_s2 & ~btn_d;
    assign unused_rise = ^btn_rise;
    assign led_onehot = (led_q != '0) && ((led_q & (led_q - LED_LSB)) == '0);

    function automatic logic [NB_LEDS-1:0] reload_led(input mode_t m);
        case (m)
            SHIFT_R: reload_led = LED_MSB;
`ifdef LED_FLASH_EN
            FLASH:   reload_led = '0;
`endif
            default: reload_led = LED_LSB;
        endcase
    endfunction

    // Scan from the top down so the lowest-index rising button wins.
    always_comb begin
        sel_hit  = 1'b0;
        sel_mode = SHIFT_L;
        for (int i = NB_SEL - 1; i >= 0; i--) begin
            if (btn_rise[i]) begin
                sel_hit  = 1'b1;
                sel_mode = mode_t'(i[1:0]);
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_d   <= '0;
            valid_d <= 1'b0;
            mode_q  <= SHIFT_L;
            led_q   <= LED_LSB;
            dir_q   <= DIR_L;
        end else begin
            btn_s1  <= i_btn;
            btn_s2  <= btn_s1;
            btn_d   <= btn_s2;
            valid_d <= i_valid;
            mode_q  <= mode_n;
            led_q   <= led_n;
            dir_q   <= dir_n;
        end
    end

    always_comb begin
        mode_n = mode_q;
        led_n  = led_q;
        dir_n  = dir_q;
        if (sel_hit) begin
            // A reload takes priority; a step arriving in the same cycle is dropped.
            mode_n = sel_mode;
            led_n  = reload_led(sel_mode);
            if (sel_mode == SHIFT_L || sel_mode == PING_PONG) dir_n = DIR_L;
        end else if (step) begin
            case (mode_q)
                SHIFT_L: begin
                    if (!led_onehot) led_n = LED_LSB;
                    else             led_n = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                end
                SHIFT_R: begin
                    if (!led_onehot) led_n = LED_MSB;
                    else             led_n = {led_q[0], led_q[NB_LEDS-1:1]};
                end
                PING_PONG: begin
                    if (!led_onehot) begin
                        led_n = LED_LSB;
                        dir_n = DIR_L;
                    end else if (dir_q == DIR_L) begin
                        led_n = led_q << 1;
                        if (led_n[NB_LEDS-1]) dir_n = DIR_R;
                    end else begin
                        led_n = led_q >> 1;
                        if (led_n[0]) dir_n = DIR_L;
                    end
                end
`ifdef LED_FLASH_EN
                FLASH: led_n = ~led_q;
`endif
                default: ;
            endcase
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_q;

endmodule
